// File: rtl/writeback.sv
// Final pipeline stage: retires instructions, formats load data, drives the
// register-file write bundle, fetch redirect/flush and the retired-instruction count.
module writeback #(
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m_valid,
  input  logic [31:0] m_instr_addr,
  input  logic [4:0]  m_rd_ind,
  input  logic        m_reg_tk,
  input  logic        m_mem_tk,
  input  logic [31:0] m_reg_dat,
  input  logic [2:0]  m_load_fn,
  input  logic [1:0]  m_addr_lo,
  input  logic        m_redirect,
  input  logic [31:0] m_redirect_addr,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        stall_out_bk,
  output logic        w_reg_tk,
  output logic        w_mem_tk,
  output logic [4:0]  w_rd_ind,
  output logic [31:0] w_reg_dat,
  output logic [31:0] w_mem_dat,
  output logic        w_flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_addr,
  output logic [63:0] instret
);

  typedef enum logic [1:0] {IDLE, WAIT_LOAD, FLUSH} state_t;

  state_t      state;
  logic [3:0]  flush_cnt;
  logic        retire;
  logic        take_redirect;
  logic        rd_nonzero;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_fmt;
  logic        unused;

  // The PC of the retiring instruction has no consumer in this stage.
  assign unused = ^m_instr_addr;

  assign rd_nonzero = (m_rd_ind != 5'd0);

  assign retire = ((state == IDLE) && m_valid && (!m_mem_tk || dmem_rvalid)) ||
                  ((state == WAIT_LOAD) && dmem_rvalid);

  assign take_redirect = retire && m_redirect && !m_mem_tk;

  // Gated by rst_n so every output reads 0 while reset is held.
  assign stall_out_bk = rst_n &&
                        (((state == IDLE) && m_valid && m_mem_tk && !dmem_rvalid) ||
                         ((state == WAIT_LOAD) && !dmem_rvalid));

  always_comb begin
    load_byte = dmem_rdata[7:0];
    case (m_addr_lo)
      2'd0: load_byte = dmem_rdata[7:0];
      2'd1: load_byte = dmem_rdata[15:8];
      2'd2: load_byte = dmem_rdata[23:16];
      2'd3: load_byte = dmem_rdata[31:24];
      default: load_byte = dmem_rdata[7:0];
    endcase
    load_half = m_addr_lo[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (m_load_fn)
      3'b000:  load_fmt = {{24{load_byte[7]}}, load_byte};
      3'b100:  load_fmt = {24'd0, load_byte};
      3'b001:  load_fmt = {{16{load_half[15]}}, load_half};
      3'b101:  load_fmt = {16'd0, load_half};
      default: load_fmt = dmem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      flush_cnt      <= 4'd0;
      w_reg_tk       <= 1'b0;
      w_mem_tk       <= 1'b0;
      w_rd_ind       <= 5'd0;
      w_reg_dat      <= 32'd0;
      w_mem_dat      <= 32'd0;
      w_flush        <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_addr  <= 32'd0;
      instret        <= 64'd0;
    end else begin
      w_reg_tk       <= retire && m_reg_tk && !m_mem_tk && rd_nonzero;
      w_mem_tk       <= retire && m_mem_tk && rd_nonzero;
      redirect_valid <= take_redirect;
      if (retire) begin
        w_rd_ind  <= m_rd_ind;
        w_reg_dat <= m_reg_dat;
        w_mem_dat <= load_fmt;
        instret   <= instret + 64'd1;
      end
      if (take_redirect) begin
        redirect_addr <= m_redirect_addr;
      end
      case (state)
        IDLE: begin
          if (take_redirect) begin
            state     <= FLUSH;
            w_flush   <= 1'b1;
            flush_cnt <= 4'(FLUSH_CYCLES - 1);
          end else if (m_valid && m_mem_tk && !dmem_rvalid) begin
            state <= WAIT_LOAD;
          end
        end
        WAIT_LOAD: begin
          if (dmem_rvalid) begin
            state <= IDLE;
          end
        end
        FLUSH: begin
          // flush_cnt counts the flush cycles still to come after this one.
          if (flush_cnt == 4'd0) begin
            state   <= IDLE;
            w_flush <= 1'b0;
          end else begin
            flush_cnt <= flush_cnt - 4'd1;
          end
        end
        default: begin
          state   <= IDLE;
          w_flush <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_writeback.sv
// Directed testbench for writeback: ALU/load retires, load formatting, rd=0,
// redirect/flush, async reset mid-load and instret wrap.
module tb_writeback;

  logic        clk;
  logic        rst_n;
  logic        m_valid;
  logic [31:0] m_instr_addr;
  logic [4:0]  m_rd_ind;
  logic        m_reg_tk;
  logic        m_mem_tk;
  logic [31:0] m_reg_dat;
  logic [2:0]  m_load_fn;
  logic [1:0]  m_addr_lo;
  logic        m_redirect;
  logic [31:0] m_redirect_addr;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        stall_out_bk;
  logic        w_reg_tk;
  logic        w_mem_tk;
  logic [4:0]  w_rd_ind;
  logic [31:0] w_reg_dat;
  logic [31:0] w_mem_dat;
  logic        w_flush;
  logic        redirect_valid;
  logic [31:0] redirect_addr;
  logic [63:0] instret;

  int          checkCount;
  int          passCount;
  logic [63:0] expInstret;

  writeback #(.FLUSH_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .m_valid(m_valid), .m_instr_addr(m_instr_addr),
    .m_rd_ind(m_rd_ind), .m_reg_tk(m_reg_tk), .m_mem_tk(m_mem_tk),
    .m_reg_dat(m_reg_dat), .m_load_fn(m_load_fn), .m_addr_lo(m_addr_lo),
    .m_redirect(m_redirect), .m_redirect_addr(m_redirect_addr),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .stall_out_bk(stall_out_bk), .w_reg_tk(w_reg_tk), .w_mem_tk(w_mem_tk),
    .w_rd_ind(w_rd_ind), .w_reg_dat(w_reg_dat), .w_mem_dat(w_mem_dat),
    .w_flush(w_flush), .redirect_valid(redirect_valid),
    .redirect_addr(redirect_addr), .instret(instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checkCount++;
    if (got === exp) passCount++;
    else $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic clearInputs();
    m_valid = 0; m_instr_addr = 32'h0; m_rd_ind = 0; m_reg_tk = 0; m_mem_tk = 0;
    m_reg_dat = 0; m_load_fn = 0; m_addr_lo = 0; m_redirect = 0;
    m_redirect_addr = 0; dmem_rvalid = 0; dmem_rdata = 0;
  endtask

  // One ALU instruction presented for one cycle starting at a negedge.
  task automatic applyStimulus(input logic [4:0] rd, input logic [31:0] dat, input string tag);
    @(negedge clk);
    m_valid = 1; m_reg_tk = 1; m_rd_ind = rd; m_reg_dat = dat; m_instr_addr = 32'h40;
    @(posedge clk); #1;
    expInstret++;
    checkOutput({tag, " w_reg_tk"}, w_reg_tk, (rd != 0));
    if (rd != 0) checkOutput({tag, " w_reg_dat"}, w_reg_dat, dat);
    checkOutput({tag, " instret"}, instret, expInstret);
    @(negedge clk);
    clearInputs();
    @(posedge clk); #1;
    checkOutput({tag, " w_reg_tk drop"}, w_reg_tk, 0);
  endtask

  task automatic applyLoad(input logic [2:0] fn, input logic [1:0] lo, input logic [31:0] rdata,
                           input logic [4:0] rd, input int waitCycles,
                           input logic [31:0] expDat, input string tag);
    @(negedge clk);
    m_valid = 1; m_mem_tk = 1; m_rd_ind = rd; m_load_fn = fn; m_addr_lo = lo;
    dmem_rdata = rdata; dmem_rvalid = 0;
    for (int i = 0; i < waitCycles; i++) begin
      #1 checkOutput({tag, " stall held"}, stall_out_bk, 1);
      @(negedge clk);
    end
    dmem_rvalid = 1;
    #1 checkOutput({tag, " stall drop"}, stall_out_bk, 0);
    @(posedge clk); #1;
    expInstret++;
    checkOutput({tag, " w_mem_tk"}, w_mem_tk, (rd != 0));
    checkOutput({tag, " w_reg_tk"}, w_reg_tk, 0);
    if (rd != 0) checkOutput({tag, " w_mem_dat"}, w_mem_dat, expDat);
    checkOutput({tag, " instret"}, instret, expInstret);
    @(negedge clk);
    clearInputs();
  endtask

  initial begin
    checkCount = 0; passCount = 0; expInstret = 0;
    clearInputs();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset w_reg_tk", w_reg_tk, 0);
    checkOutput("reset w_flush", w_flush, 0);
    checkOutput("reset instret", instret, 0);
    checkOutput("reset stall", stall_out_bk, 0);
    @(negedge clk);
    rst_n = 1;

    applyStimulus(5'd5, 32'h1234, "add");
    checkOutput("add rd", w_rd_ind, 5);
    checkOutput("add dat hold", w_reg_dat, 32'h1234);

    applyLoad(3'b000, 2'd2, 32'h0080_0000, 5'd6, 3, 32'hFFFF_FF80, "lb");
    applyLoad(3'b100, 2'd2, 32'h0080_0000, 5'd6, 3, 32'h0000_0080, "lbu");
    applyLoad(3'b001, 2'd2, 32'h8001_0000, 5'd7, 3, 32'hFFFF_8001, "lh");
    applyLoad(3'b101, 2'd0, 32'h1234_F00D, 5'd8, 0, 32'h0000_F00D, "lhu");
    applyLoad(3'b000, 2'd1, 32'h0000_7F00, 5'd9, 0, 32'h0000_007F, "lb pos");
    applyLoad(3'b100, 2'd3, 32'hAB00_0000, 5'd9, 1, 32'h0000_00AB, "lbu hi");
    applyLoad(3'b010, 2'd0, 32'hDEAD_BEEF, 5'd10, 1, 32'hDEAD_BEEF, "lw");
    applyLoad(3'b000, 2'd0, 32'h0000_00FF, 5'd0, 1, 32'h0, "load rd0");
    applyStimulus(5'd0, 32'h5555, "alu rd0");

    // JAL with redirect; a younger instruction waits out the flush.
    @(negedge clk);
    m_valid = 1; m_reg_tk = 1; m_rd_ind = 1; m_reg_dat = 32'h44;
    m_redirect = 1; m_redirect_addr = 32'h100;
    @(posedge clk); #1;
    expInstret++;
    checkOutput("jal redirect_valid", redirect_valid, 1);
    checkOutput("jal redirect_addr", redirect_addr, 32'h100);
    checkOutput("jal w_reg_tk", w_reg_tk, 1);
    checkOutput("jal w_flush 1", w_flush, 1);
    checkOutput("jal instret", instret, expInstret);
    @(negedge clk);
    m_redirect = 0; m_rd_ind = 7; m_reg_dat = 32'h77;
    @(posedge clk); #1;
    checkOutput("flush redirect drop", redirect_valid, 0);
    checkOutput("flush w_flush 2", w_flush, 1);
    checkOutput("flush no retire", w_reg_tk, 0);
    checkOutput("flush instret frozen", instret, expInstret);
    @(posedge clk); #1;
    checkOutput("flush end", w_flush, 0);
    checkOutput("flush no retire 2", w_reg_tk, 0);
    checkOutput("flush instret frozen 2", instret, expInstret);
    @(posedge clk); #1;
    expInstret++;
    checkOutput("post flush retire", w_reg_tk, 1);
    checkOutput("post flush rd", w_rd_ind, 7);
    checkOutput("post flush instret", instret, expInstret);
    @(negedge clk);
    clearInputs();

    // Async reset while a load is outstanding.
    @(negedge clk);
    m_valid = 1; m_mem_tk = 1; m_rd_ind = 3; m_load_fn = 3'b010; dmem_rdata = 32'hCAFE_F00D;
    @(posedge clk); #3;
    checkOutput("wait stall", stall_out_bk, 1);
    rst_n = 0;
    #1;
    checkOutput("async rst stall", stall_out_bk, 0);
    checkOutput("async rst instret", instret, 0);
    checkOutput("async rst w_mem_dat", w_mem_dat, 0);
    checkOutput("async rst w_rd_ind", w_rd_ind, 0);
    @(negedge clk);
    clearInputs();
    rst_n = 1;
    expInstret = 0;
    @(negedge clk);
    dmem_rvalid = 1; dmem_rdata = 32'hCAFE_F00D;
    @(posedge clk); #1;
    checkOutput("late rvalid no write", w_mem_tk, 0);
    checkOutput("late rvalid instret", instret, 0);
    @(negedge clk);
    clearInputs();

    // instret wraps modulo 2^64.
    @(negedge clk);
    force dut.instret = 64'hFFFF_FFFF_FFFF_FFFF;
    #1 release dut.instret;
    expInstret = 64'hFFFF_FFFF_FFFF_FFFF;
    applyStimulus(5'd2, 32'h9, "wrap");

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/writeback.md
Name: writeback

Overview:
- Final pipeline stage. Accepts retiring instructions from the memory stage and collects load data from the data-memory response channel.
- Formats load data by sign- or zero-extending it, then drives the registered register-file write bundle and the flush signal that the decode stage consumes.
- Issues the fetch redirect on a control-flow change and counts retired instructions.

Parameters:
- FLUSH_CYCLES, 2, number of consecutive cycles w_flush stays high after an accepted redirect (legal range 1..15).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- m_valid  in  1  memory-stage instruction present
- m_instr_addr  in  32  PC of retiring instruction
- m_rd_ind  in  5  destination register
- m_reg_tk  in  1  instruction writes ALU/link result
- m_mem_tk  in  1  instruction is a load
- m_reg_dat  in  32  ALU/link result
- m_load_fn  in  3  load funct3
- m_addr_lo  in  2  load byte offset
- m_redirect  in  1  control-flow change (mispredict/trap)
- m_redirect_addr  in  32  redirect target
- dmem_rvalid  in  1  load data valid
- dmem_rdata  in  32  raw load word
- stall_out_bk  out  1  hold request to memory stage
- w_reg_tk  out  1  write reg_dat this cycle
- w_mem_tk  out  1  write mem_dat this cycle
- w_rd_ind  out  5  write index
- w_reg_dat  out  32  ALU write data
- w_mem_dat  out  32  formatted load data
- w_flush  out  1  flush to decode/front end
- redirect_valid  out  1  one-cycle fetch redirect pulse
- redirect_addr  out  32  fetch target
- instret  out  64  retired-instruction count

Behaviour:
- Reset (async, rst_n=0): every output 0; state IDLE; flush counter 0. Reset mid-load abandons the load and writes nothing.
- States:
  - IDLE: normal operation.
  - WAIT_LOAD: a load was accepted and its data has not yet returned.
  - FLUSH: w_flush is being held for FLUSH_CYCLES cycles.
- Accept (IDLE): m_valid=1 and m_mem_tk=0 retires the instruction at the clock edge. m_valid=1, m_mem_tk=1 and dmem_rvalid=1 retires at the edge. m_valid=1, m_mem_tk=1 and dmem_rvalid=0 moves to WAIT_LOAD.
- stall_out_bk: combinational. It is 1 in IDLE while m_valid & m_mem_tk & ~dmem_rvalid, and 1 throughout WAIT_LOAD until the cycle dmem_rvalid=1, where it is 0. It is always 0 in FLUSH. While stall_out_bk=1 the memory stage holds every m_* input stable.
- WAIT_LOAD: on dmem_rvalid=1, retire the load and return to IDLE.
- Write bundle: registered, so it is visible in the cycle after the retire edge and lasts exactly one cycle.
  - w_reg_tk = m_reg_tk & ~m_mem_tk & (rd≠0).
  - w_mem_tk = m_mem_tk & (rd≠0).
  - The other w_* fields are captured at the retire edge. w_reg_tk and w_mem_tk are never both 1.
  - In cycles with no retire, w_reg_tk=w_mem_tk=0 and the data fields hold their previous values.
- Load formatting (selected by m_load_fn):
  - 000 LB: byte dmem_rdata[8*addr_lo+:8], sign-extended.
  - 100 LBU: the same byte, zero-extended.
  - 001 LH: half dmem_rdata[16*addr_lo[1]+:16], sign-extended.
  - 101 LHU: the same half, zero-extended.
  - 010 and all other codes: full word.
  - addr_lo[0] is ignored for halfword loads; misalignment is the memory stage's responsibility.
- Redirect:
  - When a non-load instruction with m_redirect=1 retires, redirect_valid=1 and redirect_addr=m_redirect_addr in the following cycle only.
  - w_flush=1 for FLUSH_CYCLES cycles starting that same cycle; state is FLUSH for that duration.
  - A link write (m_reg_tk, e.g. JAL) in the same instruction still retires.
  - m_redirect with m_mem_tk=1 is illegal; m_redirect is ignored in that case.
- FLUSH: m_valid is ignored, nothing retires, instret is frozen and dmem_rvalid is ignored. After the last flush cycle, return to IDLE.
- instret: increments by 1 at each retire edge, including retires with rd=0. It wraps modulo 2^64.
- A retire is complete when its write is presented to decode; there is no backpressure from decode.

Test Plan:
- Reset, then ADD: m_valid=1, m_reg_tk=1, rd=5, m_reg_dat=0x1234 for 1 cycle → next cycle w_reg_tk=1, w_rd_ind=5, w_reg_dat=0x1234, then w_reg_tk=0; instret=1.
- LB with m_addr_lo=2, dmem_rdata=0x00800000, dmem_rvalid held 0 for 3 cycles → stall_out_bk=1 for those 3 cycles. On the cycle rvalid=1, stall_out_bk=0 → next cycle w_mem_tk=1, w_mem_dat=0xFFFFFF80. Repeat with LBU → w_mem_dat=0x00000080; with LH and addr_lo=2, dmem_rdata=0x80010000 → w_mem_dat=0xFFFF8001.
- Write to rd=0 (ALU and load cases) → w_reg_tk=w_mem_tk=0; instret still increments.
- JAL: m_redirect=1, m_redirect_addr=0x100, m_reg_tk=1, rd=1, FLUSH_CYCLES=2 → next cycle redirect_valid=1, redirect_addr=0x100, w_reg_tk=1. w_flush=1 for exactly 2 cycles; m_valid=1 during those cycles retires nothing.
- Assert rst_n=0 asynchronously during WAIT_LOAD → all outputs 0 immediately, state IDLE. A late dmem_rvalid after release produces no write.
- Preload instret to 2^64−1 (force) and retire one instruction → instret=0.
